rvv_wb_collector: RTL and testbench

Write-back collector on the result side of the vector ALU lanes. Accepts the ALU's per-cycle result chunks (lane data + bit index) and assembles them into a full VLEN-bit destination register image. Operates in arithmetic or mask-result mode, keeps tail and masked-off elements undisturbed, then issues a single handshaked write to the vector register file. Sits between `rvv_alu` outputs (`vd`, `index`) and the VRF write port, under control of the vector sequencer.

---
 rtl/rvv_pkg.sv | 20 ++
 rtl/rvv_chunk_merge.sv | 32 +++
 rtl/rvv_wb_collector.sv | 125 ++++++++++++
 tb/tb_rvv_wb_collector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Definitions shared by the vector ALU, sequencer and write-back collector:
// collector state encoding, lane chunk width derivation and SEW decode.
package rvv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_WRITE   = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    function automatic int unsigned lane_bits(input int unsigned lane_width);
        return 32'd1 << lane_width;
    endfunction

    function automatic int unsigned sew_bits(input logic [2:0] vsew);
        return 32'd8 << vsew;
    endfunction

endpackage

// File: rtl/rvv_chunk_merge.sv
// Combinational insert of a width-bit chunk at a bit offset into a register image.
// A chunk that would run past the top of the image is dropped and flagged.
module rvv_chunk_merge #(
    parameter int unsigned VLEN = 128
) (
    input  logic [VLEN-1:0] vec_in,
    input  logic [63:0]     chunk,
    input  logic [9:0]      offset,
    input  logic [6:0]      width,
    input  logic            en,
    output logic [VLEN-1:0] vec_out,
    output logic            oor
);

    logic [10:0] end_pos;
    logic [5:0]  rel;

    assign end_pos = {1'b0, offset} + {4'b0, width};
    assign oor     = end_pos > 11'(VLEN);

    always_comb begin
        vec_out = vec_in;
        rel     = '0;
        for (int i = 0; i < VLEN; i++) begin
            rel = 6'(i - int'(offset));
            if (en && !oor && (11'(i) >= {1'b0, offset}) && (11'(i) < end_pos)) begin
                vec_out[i] = chunk[rel];
            end
        end
    end

endmodule

// File: rtl/rvv_wb_collector.sv
// Write-back collector: assembles ALU result chunks into a full destination register
// image (arith or mask-result mode, tail/inactive undisturbed) and writes it to the VRF.
module rvv_wb_collector
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN       = 10'd128,
    parameter int unsigned LANE_WIDTH = 3'b011
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [4:0]      vd_addr,
    input  logic [10:0]     vl,
    input  logic [2:0]      vsew,
    input  logic            mask_mode,
    input  logic            vm,
    input  logic [VLEN-1:0] v0_mask,
    input  logic [VLEN-1:0] old_vd,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_data,
    input  logic [9:0]      in_index,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [4:0]      wr_addr,
    output logic [VLEN-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned LANE_BITS = lane_bits(LANE_WIDTH);

    state_t          state_q, state_d;
    logic [4:0]      vd_addr_q;
    logic [10:0]     vl_q, exp_q, exp_d, cnt_q;
    logic [2:0]      vsew_q;
    logic            mask_mode_q, vm_q, err_q;
    logic [VLEN-1:0] v0_q, buf_q, merged;
    logic [9:0]      elem;
    logic [6:0]      merge_width;
    logic            active, oor, beat;
    int unsigned     sew_in, cpe_in, sew_cur, cw;

    // Expected beat count is derived from the launch-time inputs, before they are latched.
    always_comb begin
        sew_in = sew_bits(vsew);
        cpe_in = (sew_in > LANE_BITS) ? (sew_in >> LANE_WIDTH) : 32'd1;
        exp_d  = mask_mode ? vl : 11'(32'(vl) * cpe_in);
    end

    always_comb begin
        sew_cur     = sew_bits(vsew_q);
        cw          = (sew_cur < LANE_BITS) ? sew_cur : LANE_BITS;
        merge_width = mask_mode_q ? 7'd1 : 7'(cw);
        elem        = mask_mode_q ? in_index : (in_index >> ({1'b0, vsew_q} + 4'd3));
        active      = ({1'b0, elem} < vl_q) && (vm_q || |(v0_q & (VLEN'(1) << elem)));
        beat        = (state_q == ST_COLLECT) && in_valid;
    end

    rvv_chunk_merge #(
        .VLEN (VLEN)
    ) u_merge (
        .vec_in  (buf_q),
        .chunk   (in_data),
        .offset  (in_index),
        .width   (merge_width),
        .en      (active),
        .vec_out (merged),
        .oor     (oor)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (vl == 11'd0) ? ST_DONE : ST_COLLECT;
            ST_COLLECT: if (beat && (cnt_q + 11'd1 == exp_q)) state_d = ST_WRITE;
            ST_WRITE:   if (wr_ready) state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            vd_addr_q   <= '0;
            vl_q        <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            vsew_q      <= '0;
            mask_mode_q <= 1'b0;
            vm_q        <= 1'b0;
            err_q       <= 1'b0;
            v0_q        <= '0;
            buf_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                vd_addr_q   <= vd_addr;
                vl_q        <= vl;
                exp_q       <= exp_d;
                cnt_q       <= '0;
                vsew_q      <= vsew;
                mask_mode_q <= mask_mode;
                vm_q        <= vm;
                err_q       <= 1'b0;
                v0_q        <= v0_mask;
                buf_q       <= old_vd;
            end else if (beat) begin
                cnt_q <= cnt_q + 11'd1;
                buf_q <= merged;
                if (oor) err_q <= 1'b1;
            end
        end
    end

    assign in_ready = (state_q == ST_COLLECT);
    assign wr_valid = (state_q == ST_WRITE);
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign wr_addr  = vd_addr_q;
    assign wr_data  = buf_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rvv_wb_collector.sv
// Directed self-checking bench for rvv_wb_collector (VLEN=128, 8-bit lanes).
module tb_rvv_wb_collector;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [4:0]   vd_addr;
    logic [10:0]  vl;
    logic [2:0]   vsew;
    logic         mask_mode, vm;
    logic [127:0] v0_mask, old_vd;
    logic         in_valid, in_ready;
    logic [63:0]  in_data;
    logic [9:0]   in_index;
    logic         wr_valid, wr_ready;
    logic [4:0]   wr_addr;
    logic [127:0] wr_data;
    logic         busy, done, err;

    int total = 0;
    int bad   = 0;

    logic [127:0] expv;

    rvv_wb_collector #(
        .VLEN       (128),
        .LANE_WIDTH (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .vd_addr   (vd_addr),
        .vl        (vl),
        .vsew      (vsew),
        .mask_mode (mask_mode),
        .vm        (vm),
        .v0_mask   (v0_mask),
        .old_vd    (old_vd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_index  (in_index),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [4:0] a, input logic [10:0] n, input logic [2:0] s,
                          input logic mm, input logic m, input logic [127:0] v0,
                          input logic [127:0] old);
        vd_addr = a; vl = n; vsew = s; mask_mode = mm; vm = m; v0_mask = v0; old_vd = old;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [9:0] idx, input logic [63:0] d);
        in_valid = 1'b1; in_index = idx; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic accept_write(input string tag);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk({tag, "_done"}, 128'(done), 128'd1);
        tick();
        chk({tag, "_idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; vd_addr = '0; vl = '0; vsew = '0; mask_mode = 1'b0;
        vm = 1'b1; v0_mask = '0; old_vd = '0; in_valid = 1'b0; in_data = '0; in_index = '0;
        wr_ready = 1'b0;
        #12;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_outs", 128'({in_ready, wr_valid, done, err}), 128'd0);
        chk("rst_addr", 128'(wr_addr), 128'd0);
        chk("rst_data", wr_data, 128'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // Arith SEW=32, 16 byte chunks
        launch(5'd3, 11'd4, 3'd2, 1'b0, 1'b1, '0, '0);
        chk("a32_busy", 128'(busy), 128'd1);
        chk("a32_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 15; i++) beat(10'(8 * i), 64'(i));
        chk("a32_early_wv", 128'(wr_valid), 128'd0);
        beat(10'd120, 64'h0F);
        chk("a32_wv", 128'(wr_valid), 128'd1);
        chk("a32_data", wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("a32_addr", 128'(wr_addr), 128'd3);
        chk("a32_rdy_off", 128'(in_ready), 128'd0);
        accept_write("a32");

        // Tail undisturbed, upper in_data bits ignored
        launch(5'd4, 11'd3, 3'd0, 1'b0, 1'b1, '0, '1);
        beat(10'd0, 64'hDEADBEEF_CAFE0011);
        beat(10'd8, 64'hFFFF_FF22);
        beat(10'd16, 64'h1233);
        expv = {{104{1'b1}}, 24'h332211};
        chk("tail_wv", 128'(wr_valid), 128'd1);
        chk("tail_data", wr_data, expv);
        accept_write("tail");

        // Masked elements keep old value
        launch(5'd5, 11'd4, 3'd0, 1'b0, 1'b0, 128'b0101, '0);
        for (int i = 0; i < 4; i++) beat(10'(8 * i), 64'hAA);
        chk("msk_data", wr_data, 128'h00AA00AA);
        accept_write("msk");

        // Mask-result mode, bits above vl undisturbed
        launch(5'd6, 11'd8, 3'd0, 1'b1, 1'b1, '0, {{120{1'b1}}, 8'h00});
        expv = 128'b01001101;
        for (int i = 0; i < 8; i++) beat(10'(i), {63'h7F, expv[i]});
        expv = {{120{1'b1}}, 8'h4D};
        chk("mm_wv", 128'(wr_valid), 128'd1);
        chk("mm_data", wr_data, expv);
        accept_write("mm");

        // Backpressure: image and request held, stray beat/start ignored
        launch(5'd17, 11'd1, 3'd0, 1'b0, 1'b1, '0, '0);
        beat(10'd0, 64'h5A);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wv", 128'(wr_valid), 128'd1);
            chk("bp_data", wr_data, 128'h5A);
            chk("bp_addr", 128'(wr_addr), 128'd17);
            chk("bp_done", 128'(done), 128'd0);
            in_valid = (i == 2); in_index = 10'd8; in_data = 64'hFF; start = (i == 3);
            tick();
            in_valid = 1'b0; start = 1'b0;
        end
        chk("bp_data_end", wr_data, 128'h5A);
        accept_write("bp");

        // vl == 0: no VRF write
        launch(5'd9, 11'd0, 3'd0, 1'b0, 1'b1, '0, '1);
        chk("vl0_done", 128'(done), 128'd1);
        chk("vl0_wv", 128'(wr_valid), 128'd0);
        tick();
        chk("vl0_idle", 128'({busy, done, wr_valid}), 128'd0);

        // Out-of-range chunk: flagged, buffer untouched
        launch(5'd10, 11'd4, 3'd2, 1'b0, 1'b1, '0, '1);
        beat(10'd124, 64'h5A);
        chk("oor_err", 128'(err), 128'd1);
        for (int i = 0; i < 15; i++) beat(10'(8 * i), 64'(i));
        chk("oor_wv", 128'(wr_valid), 128'd1);
        chk("oor_data", wr_data, 128'hFF0E0D0C0B0A09080706050403020100);
        chk("oor_err_hold", 128'(err), 128'd1);
        accept_write("oor");

        // Reset in the middle of COLLECT
        launch(5'd12, 11'd4, 3'd0, 1'b0, 1'b1, '0, '1);
        chk("rs_err_clr", 128'(err), 128'd0);
        beat(10'd124, 64'h77);
        chk("rs_err_set", 128'(err), 128'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rs_ctl", 128'({busy, in_ready, wr_valid, done, err}), 128'd0);
        chk("rs_addr", 128'(wr_addr), 128'd0);
        chk("rs_data", wr_data, 128'd0);
        tick();
        resetn = 1'b1;
        in_valid = 1'b1; in_index = 10'd0; in_data = 64'h33;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rs_after", 128'({busy, wr_valid}), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
